// File: rtl/debounce_multi_if.sv
// rtl/debounce_multi_if.sv - pin-side bundle for the multi-channel debouncer
//
// Purpose: groups the raw inputs and the debounced outputs of debounce_multi.
// Signals (CHANNELS bits each, bit i = channel i):
//   inp  : raw asynchronous inputs            (master drives)
//   out  : debounced level                    (slave drives)
//   rise : one-cycle strobe, out went 0->1    (slave drives)
//   fall : one-cycle strobe, out went 1->0    (slave drives)
//   long : one-cycle long-press strobe        (slave drives)
interface debounce_multi_if #(
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0] inp;
   logic [CHANNELS-1:0] out;
   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] fall;
   logic [CHANNELS-1:0] long;

   modport master (
      output inp,
      input  out,
      input  rise,
      input  fall,
      input  long
   );

   modport slave (
      input  inp,
      output out,
      output rise,
      output fall,
      output long
   );
endinterface

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - parametrised multi-channel input debouncer with edge strobes
//
// Purpose: per channel, synchronises a noisy asynchronous input, accepts a new
// level only after it has been stable for BOUNCING_TIME cycles, and emits
// registered one-cycle rise/fall strobes in the cycle the new level appears.
// Optional long-press strobe enabled by defining DEBOUNCE_LONGPRESS_EN.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : debounce_multi_if.slave (inp in; out/rise/fall/long out)
module debounce_multi #(
   parameter int CHANNELS      = 4,
   parameter int BOUNCING_TIME = 10,
   parameter int SYNC_STAGES   = 2,
   parameter int LONG_TIME     = 1000
) (
   input  logic             clk,
   input  logic             rst,
   debounce_multi_if.slave  bus
);

   if (CHANNELS < 1 || BOUNCING_TIME < 1 || SYNC_STAGES < 2 || LONG_TIME < 1) begin : g_bad_param
      $error("debounce_multi: parameter out of range");
   end

   localparam int              CW       = $clog2(BOUNCING_TIME + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(BOUNCING_TIME - 1);

   logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
   logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
   logic [CHANNELS-1:0]                  out_q, out_d;
   logic [CHANNELS-1:0]                  rise_q, rise_d;
   logic [CHANNELS-1:0]                  fall_q, fall_d;
   logic [CHANNELS-1:0]                  s;

   // Plain flop chain: stage 0 samples the pin, nothing between stages.
   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = bus.inp;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // The count runs only while the synchronised level disagrees with out;
   // any agreeing cycle restarts it, so only an unbroken window flips out.
   always_comb begin
      cnt_d  = cnt_q;
      out_d  = out_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (s[i] == out_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]  = '0;
            out_d[i]  = s[i];
            rise_d[i] = s[i];
            fall_d[i] = ~s[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         cnt_q  <= '0;
         out_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         out_q  <= out_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.rise = rise_q;
   assign bus.fall = fall_q;

`ifdef DEBOUNCE_LONGPRESS_EN
   localparam int            HW       = $clog2(LONG_TIME + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TIME);
   localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_TIME - 1);

   logic [CHANNELS-1:0][HW-1:0] hold_q, hold_d;
   logic [CHANNELS-1:0]         long_q, long_d;

   // Hold counter saturates, so the strobe fires once per press; a low
   // out clears it and re-arms the next press.
   always_comb begin
      hold_d = '0;
      long_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (out_q[i]) begin
            if (hold_q[i] != HOLD_MAX) begin
               hold_d[i] = hold_q[i] + HW'(1);
            end else begin
               hold_d[i] = hold_q[i];
            end
            long_d[i] = (hold_q[i] == HOLD_PRE);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_q <= '0;
         long_q <= '0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign bus.long = long_q;
`else
   assign bus.long = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - directed self-checking bench for debounce_multi
module tb_debounce_multi;

   localparam int CH = 4;
   localparam int BT = 10;
   localparam int SS = 2;
   localparam int LT = 50;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   debounce_multi_if #(.CHANNELS(CH)) bus ();

   debounce_multi #(
      .CHANNELS      (CH),
      .BOUNCING_TIME (BT),
      .SYNC_STAGES   (SS),
      .LONG_TIME     (LT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [CH-1:0] exp_out, exp_rise;
      rst     = 1'b0;
      bus.inp = 4'b1111;
      #3;
      total++;
      if ({bus.out, bus.rise, bus.fall, bus.long} !== 16'h0) begin
         bad++;
         $display("FAIL reset_hold_a: got %h want 0000", {bus.out, bus.rise, bus.fall, bus.long});
      end
      #10;
      total++;
      if ({bus.out, bus.rise, bus.fall, bus.long} !== 16'h0) begin
         bad++;
         $display("FAIL reset_hold_b: got %h want 0000", {bus.out, bus.rise, bus.fall, bus.long});
      end
      #7;
      rst = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         tick();
         exp_out  = (c >= 12) ? 4'b1111 : 4'b0000;
         exp_rise = (c == 12) ? 4'b1111 : 4'b0000;
         total++;
         if (bus.out !== exp_out || bus.rise !== exp_rise || bus.fall !== 4'b0000) begin
            bad++;
            $display("FAIL reset_release c=%0d: out=%b rise=%b fall=%b want out=%b rise=%b fall=0000",
                     c, bus.out, bus.rise, bus.fall, exp_out, exp_rise);
         end
      end
   endtask

   task automatic test_bounce();
      logic          v;
      logic [CH-1:0] exp_rise;
      logic          exp_out0;
      bus.inp = 4'b1110;
      for (int c = 1; c <= 14; c++) begin
         tick();
         total++;
         if (bus.fall !== ((c == 12) ? 4'b0001 : 4'b0000)) begin
            bad++;
            $display("FAIL bounce_prep_fall c=%0d: got %b", c, bus.fall);
         end
      end
      v = 1'b0;
      for (int t = 0; t < 10; t++) begin
         v          = ~v;
         bus.inp[0] = v;
         for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (bus.rise !== 4'b0000 || bus.out[0] !== 1'b0) begin
               bad++;
               $display("FAIL bounce_reject t=%0d: rise=%b out0=%b want rise=0000 out0=0",
                        t, bus.rise, bus.out[0]);
            end
         end
      end
      bus.inp[0] = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         tick();
         exp_out0 = (c >= 12);
         exp_rise = (c == 12) ? 4'b0001 : 4'b0000;
         total++;
         if (bus.rise !== exp_rise || bus.out[0] !== exp_out0) begin
            bad++;
            $display("FAIL bounce_settle c=%0d: rise=%b out0=%b want rise=%b out0=%b",
                     c, bus.rise, bus.out[0], exp_rise, exp_out0);
         end
      end
   endtask

   task automatic test_window();
      logic [CH-1:0] exp_fall, exp_rise;
      logic          exp_out1;
      bus.inp[1] = 1'b0;
      for (int c = 1; c <= 29; c++) begin
         tick();
         if (c == 9) bus.inp[1] = 1'b1;
         total++;
         if (bus.fall !== 4'b0000 || bus.out !== 4'b1111) begin
            bad++;
            $display("FAIL window_9 c=%0d: fall=%b out=%b want fall=0000 out=1111",
                     c, bus.fall, bus.out);
         end
      end
      bus.inp[1] = 1'b0;
      for (int c = 1; c <= 24; c++) begin
         tick();
         if (c == 10) bus.inp[1] = 1'b1;
         exp_fall = (c == 12) ? 4'b0010 : 4'b0000;
         exp_rise = (c == 22) ? 4'b0010 : 4'b0000;
         exp_out1 = (c < 12) || (c >= 22);
         total++;
         if (bus.fall !== exp_fall || bus.rise !== exp_rise || bus.out[1] !== exp_out1) begin
            bad++;
            $display("FAIL window_10 c=%0d: fall=%b rise=%b out1=%b want fall=%b rise=%b out1=%b",
                     c, bus.fall, bus.rise, bus.out[1], exp_fall, exp_rise, exp_out1);
         end
      end
   endtask

   task automatic test_independence();
      logic [CH-1:0] exp_rise, exp_out;
      bus.inp[3:2] = 2'b00;
      repeat (14) tick();
      bus.inp[2] = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         tick();
         if (c == 5) bus.inp[3] = 1'b1;
         exp_rise = {c == 17, c == 12, 2'b00};
         exp_out  = {c >= 17, c >= 12, 2'b11};
         total++;
         if (bus.rise !== exp_rise || bus.out !== exp_out || bus.fall !== 4'b0000) begin
            bad++;
            $display("FAIL independence c=%0d: rise=%b out=%b fall=%b want rise=%b out=%b fall=0000",
                     c, bus.rise, bus.out, bus.fall, exp_rise, exp_out);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [CH-1:0] exp_rise, exp_out;
      bus.inp[0] = 1'b0;
      repeat (14) tick();
      bus.inp[0] = 1'b1;
      repeat (6) tick();
      rst = 1'b0;
      #1;
      total++;
      if ({bus.out, bus.rise, bus.fall, bus.long} !== 16'h0) begin
         bad++;
         $display("FAIL reset_mid_assert: got %h want 0000", {bus.out, bus.rise, bus.fall, bus.long});
      end
      for (int c = 1; c <= 2; c++) begin
         tick();
         total++;
         if (bus.out !== 4'b0000 || bus.rise !== 4'b0000) begin
            bad++;
            $display("FAIL reset_mid_held c=%0d: out=%b rise=%b want 0000", c, bus.out, bus.rise);
         end
      end
      rst = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         tick();
         exp_rise = (c == 12) ? 4'b1111 : 4'b0000;
         exp_out  = (c >= 12) ? 4'b1111 : 4'b0000;
         total++;
         if (bus.rise !== exp_rise || bus.out !== exp_out) begin
            bad++;
            $display("FAIL reset_mid_release c=%0d: rise=%b out=%b want rise=%b out=%b",
                     c, bus.rise, bus.out, exp_rise, exp_out);
         end
      end
   endtask

   task automatic test_long();
      logic [CH-1:0] exp_long;
      int            span;
      bus.inp = 4'b0000;
      repeat (14) tick();
      for (int p = 0; p < 2; p++) begin
         bus.inp = 4'b0001;
         repeat (11) tick();
         tick();
         total++;
         if (bus.rise !== 4'b0001) begin
            bad++;
            $display("FAIL long_press%0d_rise: got %b want 0001", p, bus.rise);
         end
         span = (p == 0) ? 250 : 60;
         for (int c = 1; c <= span; c++) begin
            tick();
`ifdef DEBOUNCE_LONGPRESS_EN
            exp_long = (c == LT) ? 4'b0001 : 4'b0000;
`else
            exp_long = 4'b0000;
`endif
            total++;
            if (bus.long !== exp_long) begin
               bad++;
               $display("FAIL long_press%0d c=%0d: long=%b want %b", p, c, bus.long, exp_long);
            end
         end
         bus.inp = 4'b0000;
         for (int c = 1; c <= 14; c++) begin
            tick();
            total++;
            if (bus.long !== 4'b0000) begin
               bad++;
               $display("FAIL long_release%0d c=%0d: long=%b want 0000", p, c, bus.long);
            end
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_bounce();
      test_window();
      test_independence();
      test_reset_mid();
      test_long();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised multi-channel successor to the single-input debouncer, for buttons, switches and other noisy asynchronous inputs. Each channel has its own input synchroniser and stability counter. Each channel produces a clean level plus one-cycle rise/fall strobes. Sits between board-level pins and control FSMs so downstream logic needs no edge detectors of its own.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
BOUNCING_TIME, 10, consecutive stable clk cycles required before a level change is accepted (>=1)
SYNC_STAGES, 2, flip-flop stages in each channel's input synchroniser (>=2)
LONG_TIME, 1000, clk cycles out must stay high before long strobe fires (used only with optional feature, >=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset; async assert, release sampled on clk
inp  input  CHANNELS  raw asynchronous inputs, bit i = channel i
out  output  CHANNELS  debounced level per channel
rise  output  CHANNELS  one-cycle strobe, channel i out went 0->1
fall  output  CHANNELS  one-cycle strobe, channel i out went 1->0
long  output  CHANNELS  one-cycle strobe, long-press detected (optional feature)

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-low. Every flop clears immediately when rst=0.
- Reset values: out=0, rise=0, fall=0, long=0, synchroniser stages=0, all counters=0.
- Synchroniser: per channel, SYNC_STAGES-deep flop chain. s_i is its last stage. No logic between stages.
- Stability counter cnt_i: width $clog2(BOUNCING_TIME+1).
  - If s_i == out[i]: cnt_i <= 0.
  - If s_i != out[i] and cnt_i < BOUNCING_TIME-1: cnt_i increments.
  - If s_i != out[i] and cnt_i == BOUNCING_TIME-1: out[i] <= s_i and cnt_i <= 0.
- Net effect: out[i] toggles only after s_i has differed from out[i] for BOUNCING_TIME consecutive cycles. Any single-cycle return to the old level restarts the count from 0.
- Latency: a clean edge on inp[i] appears on out[i] SYNC_STAGES+BOUNCING_TIME cycles later (2+10=12 at defaults).
- Strobes: rise[i]/fall[i] are registered and high for exactly the one cycle in which out[i] first shows its new value. They are never both high. They are not asserted on reset release.
- Channels are fully independent. Simultaneous changes on several channels are each handled on their own counter with no interaction.
- Reset-release edge case: if inp[i] is held 1 through reset release, out[i] rises after full latency and rise[i] pulses once. This is intended.
- Reset mid-count discards all partial counts. After release, a full BOUNCING_TIME stable window is required again.
- No counter wraps; cnt_i is bounded at BOUNCING_TIME-1 by construction.

Optional Feature:
- Macro: DEBOUNCE_LONGPRESS_EN.
- Defined: each channel has hold counter h_i, width $clog2(LONG_TIME+1).
  - While out[i]=1, h_i increments, saturating at LONG_TIME.
  - long[i] pulses for one cycle when h_i transitions from LONG_TIME-1 to LONG_TIME. That cycle is LONG_TIME cycles after the cycle in which rise[i] was high.
  - No repeat while held.
  - h_i <= 0 in any cycle where out[i]=0; fall re-arms.
  - The counter and strobe are reset to 0 by rst.
- Not defined: long is tied to 0; no hold counters are synthesised. The port list is unchanged.

Test Plan:
- Bench setup: CHANNELS=4, BOUNCING_TIME=10, SYNC_STAGES=2, LONG_TIME=50, 10 ns clk.
- Reset: rst=0 for 20 ns with inp=4'b1111 -> out=rise=fall=long=0 during reset. After release, out becomes 4'b1111 at cycle 12 with rise=4'b1111 for one cycle.
- Bounce rejection: inp[0] toggles every 2 cycles for 10 toggles, then holds 1 -> no rise[0] during bouncing. out[0]=1 and rise[0] pulse exactly 12 cycles after the final edge.
- Window boundary: with out[1]=1, drop inp[1] low for 9 cycles then high -> out[1] stays 1, fall[1]=0. Drop it low for 10 cycles -> fall[1] pulses once and out[1]=0.
- Independence: raise inp[2] at cycle 0 and inp[3] at cycle 5 -> rise[2] at cycle 12, rise[3] at cycle 17. Other channels stay unchanged.
- Reset mid-operation: raise inp[0], assert rst at cycle 6 for 2 cycles, keep inp[0]=1 -> out[0]=0 immediately. After release, rise[0] occurs only after a full 12 cycles.
- Long press (macro defined): hold inp[0]=1 -> long[0] pulses once 50 cycles after the rise[0] cycle, with no second pulse over the next 200 cycles. Release and press again -> long[0] pulses again. Macro undefined -> long stays 0 throughout.
